// File: rtl/rv32i_id_stage_if.sv
// Fetch/writeback/ID-EX signal bundle of the RV32I decode stage.
// master = surrounding pipeline (fetch, writeback, execute); slave = rv32i_id_stage.
interface rv32i_id_stage_if;
   logic [31:0] iw_in;
   logic [31:0] pc_in;
   logic        jump_en_in;
   logic        wb_en;
   logic [4:0]  wb_reg;
   logic [31:0] wb_data;
   logic        jump_en_out;
   logic [31:0] jump_addr;
   logic        valid_out;
   logic [31:0] pc_out;
   logic [31:0] iw_out;
   logic [31:0] rs1_data_out;
   logic [31:0] rs2_data_out;
   logic [31:0] imm_out;
   logic [4:0]  rd_out;
   logic        wb_en_out;
   logic        illegal_out;

   // valid_out qualifies every ID/EX field; there is no ready, so EX accepts
   // one slot per cycle and a bubble is simply valid_out=0.
   modport master (
      output iw_in, pc_in, jump_en_in, wb_en, wb_reg, wb_data,
      input  jump_en_out, jump_addr, valid_out, pc_out, iw_out, rs1_data_out,
             rs2_data_out, imm_out, rd_out, wb_en_out, illegal_out
   );

   modport slave (
      input  iw_in, pc_in, jump_en_in, wb_en, wb_reg, wb_data,
      output jump_en_out, jump_addr, valid_out, pc_out, iw_out, rs1_data_out,
             rs2_data_out, imm_out, rd_out, wb_en_out, illegal_out
   );
endinterface

// File: rtl/rv32i_id_stage.sv
// RV32I decode stage: register file, immediate generation, jump/branch resolution, ID/EX register.
// Optional macro ID_WB_BYPASS_EN forwards same-cycle writeback data to register reads.
module rv32i_id_stage #(
   parameter logic [31:0] RESET_PC = 32'd0
) (
   input logic             clk,
   input logic             reset,
   rv32i_id_stage_if.slave id
);
   localparam logic [6:0]  OP_LUI    = 7'b0110111;
   localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
   localparam logic [6:0]  OP_JAL    = 7'b1101111;
   localparam logic [6:0]  OP_JALR   = 7'b1100111;
   localparam logic [6:0]  OP_BRANCH = 7'b1100011;
   localparam logic [6:0]  OP_LOAD   = 7'b0000011;
   localparam logic [6:0]  OP_STORE  = 7'b0100011;
   localparam logic [6:0]  OP_IMM    = 7'b0010011;
   localparam logic [6:0]  OP_OP     = 7'b0110011;
   localparam logic [6:0]  OP_FENCE  = 7'b0001111;
   localparam logic [6:0]  OP_SYSTEM = 7'b1110011;
   localparam logic [31:0] NOP       = 32'h0000_0013;

   logic [31:0] rf [32];

   logic [6:0]  opcode;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] rs1_val, rs2_val, imm;
   logic        live, legal, writes, is_jal, is_jalr, is_branch, taken;

   assign opcode = id.iw_in[6:0];
   assign rd     = id.iw_in[11:7];
   assign funct3 = id.iw_in[14:12];
   assign rs1    = id.iw_in[19:15];
   assign rs2    = id.iw_in[24:20];

   assign imm_i = {{20{id.iw_in[31]}}, id.iw_in[31:20]};
   assign imm_s = {{20{id.iw_in[31]}}, id.iw_in[31:25], id.iw_in[11:7]};
   assign imm_b = {{19{id.iw_in[31]}}, id.iw_in[31], id.iw_in[7], id.iw_in[30:25],
                   id.iw_in[11:8], 1'b0};
   assign imm_u = {id.iw_in[31:12], 12'd0};
   assign imm_j = {{11{id.iw_in[31]}}, id.iw_in[31], id.iw_in[19:12], id.iw_in[20],
                   id.iw_in[30:21], 1'b0};

   // A slot fetched behind a taken jump is wrong-path and must not act.
   assign live = !id.jump_en_in && !reset;

   always_comb begin
      rs1_val = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
      rs2_val = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
`ifdef ID_WB_BYPASS_EN
      if (id.wb_en && id.wb_reg != 5'd0 && id.wb_reg == rs1) rs1_val = id.wb_data;
      if (id.wb_en && id.wb_reg != 5'd0 && id.wb_reg == rs2) rs2_val = id.wb_data;
`endif
   end

   always_comb begin
      legal     = 1'b0;
      writes    = 1'b0;
      imm       = 32'd0;
      is_jal    = 1'b0;
      is_jalr   = 1'b0;
      is_branch = 1'b0;
      case (opcode)
         OP_LUI, OP_AUIPC: begin legal = 1'b1; writes = 1'b1; imm = imm_u; end
         OP_JAL:           begin legal = 1'b1; writes = 1'b1; imm = imm_j; is_jal = 1'b1; end
         OP_JALR:          begin legal = 1'b1; writes = 1'b1; imm = imm_i; is_jalr = 1'b1; end
         OP_BRANCH: begin
            legal     = (funct3 != 3'b010) && (funct3 != 3'b011);
            imm       = imm_b;
            is_branch = 1'b1;
         end
         OP_LOAD, OP_IMM:     begin legal = 1'b1; writes = 1'b1; imm = imm_i; end
         OP_STORE:            begin legal = 1'b1; imm = imm_s; end
         OP_OP:               begin legal = 1'b1; writes = 1'b1; end
         OP_FENCE, OP_SYSTEM: begin legal = 1'b1; imm = imm_i; end
         default: ;
      endcase
   end

   always_comb begin
      case (funct3)
         3'b000:  taken = (rs1_val == rs2_val);
         3'b001:  taken = (rs1_val != rs2_val);
         3'b100:  taken = ($signed(rs1_val) <  $signed(rs2_val));
         3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
         3'b110:  taken = (rs1_val <  rs2_val);
         3'b111:  taken = (rs1_val >= rs2_val);
         default: taken = 1'b0;
      endcase
   end

   assign id.jump_en_out = live && legal && (is_jal || is_jalr || (is_branch && taken));
   // imm already holds immJ for JAL and immB for branches.
   assign id.jump_addr   = is_jalr ? ((rs1_val + imm_i) & ~32'd1) : (id.pc_in + imm);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
      end else if (id.wb_en && id.wb_reg != 5'd0) begin
         rf[id.wb_reg] <= id.wb_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || !live || !legal) begin
         id.valid_out    <= 1'b0;
         id.wb_en_out    <= 1'b0;
         id.illegal_out  <= live && !legal;
         id.pc_out       <= RESET_PC;
         id.iw_out       <= NOP;
         id.rs1_data_out <= 32'd0;
         id.rs2_data_out <= 32'd0;
         id.imm_out      <= 32'd0;
         id.rd_out       <= 5'd0;
      end else begin
         id.valid_out    <= 1'b1;
         id.wb_en_out    <= writes && (rd != 5'd0);
         id.illegal_out  <= 1'b0;
         id.pc_out       <= id.pc_in;
         id.iw_out       <= id.iw_in;
         id.rs1_data_out <= rs1_val;
         id.rs2_data_out <= rs2_val;
         id.imm_out      <= imm;
         id.rd_out       <= writes ? rd : 5'd0;
      end
   end
endmodule

// File: doc/rv32i_id_stage.md
# rv32i_id_stage

Instruction decode stage of the RV32I pipeline. Sits directly downstream of the fetch stage: it consumes the fetched instruction word and its PC, reads the 32×32 register file, and generates immediates. It resolves JAL/JALR/branches, drives the jump request back to fetch, and squashes the one wrong-path instruction that follows a taken jump. Results are registered into the ID/EX pipeline register for the execute stage.

## Interface
Parameters:
- RESET_PC, 32'd0, PC value placed on pc_out while in reset/bubble

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- iw_in  in  32  instruction word from fetch
- pc_in  in  32  PC of iw_in, from fetch
- jump_en_in  in  1  from fetch; high = iw_in is wrong-path (fetched behind a taken jump)
- wb_en  in  1  writeback write enable
- wb_reg  in  5  writeback destination register
- wb_data  in  32  writeback data
- jump_en_out  out  1  combinational; take jump this cycle, to fetch
- jump_addr  out  32  combinational; jump target, to fetch
- valid_out  out  1  registered; ID/EX slot holds a real instruction
- pc_out  out  32  registered PC
- iw_out  out  32  registered instruction word (EX decodes funct fields)
- rs1_data_out, rs2_data_out  out  32 each  registered operands
- imm_out  out  32  registered sign-extended immediate
- rd_out  out  5  registered destination register
- wb_en_out  out  1  registered; instruction writes rd (rd≠0)
- illegal_out  out  1  registered; unsupported opcode seen

## Operation
- Squash: slot is live when !jump_en_in && !reset. Dead slot → no jump request, registers a bubble.
- Decode by opcode[6:0]: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, FENCE, SYSTEM. Any other opcode → illegal_out=1, treated as bubble (valid_out=0, wb_en_out=0).
- Immediates: I, S, B, U, J formats per RV32I, sign-extended from bit 31; R-type imm=0.
- Register file: 32×32; x0 reads 0 always. Write at posedge when wb_en && wb_reg≠0. Reset clears all 32 entries.
- Jump resolution (live slot only):
  - JAL: target = pc_in + immJ.
  - JALR: target = (rs1 + immI) & ~32'd1.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU: compare rs1/rs2 (signed for BLT/BGE, unsigned for *U); taken → target = pc_in + immB; not taken → jump_en_out=0.
  - Invalid funct3 under BRANCH → illegal.
- jump_addr is don't-care when jump_en_out=0; fetch uses bits [31:2] only.
- wb_en_out=1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP when rd≠0.
- Arithmetic is 32-bit modulo; carries are discarded.

## Timing
- Reset (cycle with reset=1): at the edge, valid_out=0, wb_en_out=0, illegal_out=0, pc_out=RESET_PC, iw_out=32'h00000013 (NOP), rs1/rs2/imm=0, rd_out=0, regfile cleared. jump_en_out is forced 0 combinationally while reset is high. Reset mid-operation discards the ID/EX contents.
- Latency: iw_in at cycle t appears on ID/EX outputs after the edge ending t.
- Jump: jump_en_out asserted in cycle t; fetch loads the target at that edge. At t+1, jump_en_in=1 and iw_in is PC+4 → squashed. The first target instruction arrives at t+2 (one bubble).
- Back-to-back: a jump in the squashed slot is ignored; it never produces two consecutive jump cycles.
- Writeback and read of the same register in the same cycle: see Configuration. Writing x0 is ignored in every case.

## Configuration
- ID_WB_BYPASS_EN defined: a read of register r in the same cycle as wb_en && wb_reg==r (r≠0) returns wb_data. This applies to the operands, branch compare and JALR target.
- ID_WB_BYPASS_EN undefined: the read returns the pre-write value. Software or the hazard unit must cover the gap.

## Test plan
- Reset then feed ADDI x1,x0,5 (32'h00500093) at pc 0 → next cycle valid_out=1, imm_out=5, rd_out=1, wb_en_out=1, jump_en_out stayed 0.
- JAL x1,+16 at pc 32'h100 → jump_en_out=1, jump_addr=32'h110 same cycle. Next cycle with jump_en_in=1 and a BEQ x0,x0 → jump_en_out=0, valid_out=0 after edge.
- Preload x2=-1, x3=1. BLT x2,x3,+8 at pc 32'h40 → jump to 32'h48. BLTU x2,x3,+8 → jump_en_out=0.
- JALR x0,3(x5) with x5=32'h200 → jump_addr=32'h202.
- wb_en=1, wb_reg=7, wb_data=32'hDEAD; same-cycle ADD x8,x7,x0 → rs1_data_out=32'hDEAD with ID_WB_BYPASS_EN, old x7 without. Write to x0 → x0 still reads 0.
- Opcode 7'b0000000 → illegal_out=1, valid_out=0. Reset asserted mid-stream → all outputs at reset values next cycle and x7 reads 0.
